// File: rtl/posit_norm_adjust_if.sv
// Operand/result bundle between the posit multiplier core, the normalisation
// stage and the posit encoder.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_valid/in_ready move operands into the block. Once
// out_valid is raised, it and every result field stay stable until an edge
// with out_ready high.
interface posit_norm_adjust_if #(
    parameter int MANT_W  = 64,
    parameter int SCALE_W = 10,
    parameter int ES      = 3
);
    localparam int SH_W = $clog2(MANT_W);

    logic                    in_valid;
    logic                    in_ready;
    logic [SCALE_W-1:0]      scale_in;
    logic [MANT_W-1:0]       mant_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [SCALE_W-1:0]      scale_out;
    logic [MANT_W-1:0]       mant_out;
    logic [SH_W-1:0]         shift_amt;
    logic                    right_sh;
    logic                    sticky;
    logic                    zero;
    logic                    sat;
    logic [ES-1:0]           exp_out;
    logic [SCALE_W-ES-2:0]   regime_out;
    logic                    scale_sign;

    // Normalisation stage side
    modport slave (
        input  in_valid, scale_in, mant_in, out_ready,
        output in_ready, out_valid, scale_out, mant_out, shift_amt, right_sh,
               sticky, zero, sat, exp_out, regime_out, scale_sign
    );

    // Producer / consumer side
    modport master (
        output in_valid, scale_in, mant_in, out_ready,
        input  in_ready, out_valid, scale_out, mant_out, shift_amt, right_sh,
               sticky, zero, sat, exp_out, regime_out, scale_sign
    );
endinterface

// File: rtl/posit_norm_adjust.sv
// Posit product normalisation: moves the hidden bit of the mantissa product
// to bit MANT_W-2. It shifts left by up to SHIFT_STEP bits per cycle, or right
// by one bit with a sticky bit. The scale is adjusted with saturation, and
// the registered result is split into exponent, regime and sign fields.
module posit_norm_adjust #(
    parameter int MANT_W     = 64,
    parameter int SCALE_W    = 10,
    parameter int ES         = 3,
    parameter int SHIFT_STEP = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    posit_norm_adjust_if.slave   bus,
    output logic [1:0]           state_dbg
);
    localparam int SH_W = $clog2(MANT_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nx;

    // Working registers for the operand in flight
    logic [MANT_W-1:0]  m_q, m_nx;
    logic [SCALE_W-1:0] sc_q, sc_nx;
    logic [SH_W-1:0]    cnt_q, cnt_nx;
    logic               sat_q, sat_nx;

    // Published result registers
    logic               ov_q, ov_nx;
    logic [SCALE_W-1:0] so_q, so_nx;
    logic [MANT_W-1:0]  mo_q, mo_nx;
    logic [SH_W-1:0]    sa_q, sa_nx;
    logic               rs_q, rs_nx;
    logic               st_q, st_nx;
    logic               z_q, z_nx;
    logic               sat_o_q, sat_o_nx;

    logic [SH_W-1:0]    lz;
    logic [SH_W-1:0]    k;
    logic [SCALE_W:0]   sc_ext, sc_dec, sc_inc;

    // Signed overflow of a SCALE_W+1 bit result shows up as its top two bits differing
    function automatic logic ovf(input logic [SCALE_W:0] v);
        return v[SCALE_W] ^ v[SCALE_W-1];
    endfunction

    function automatic logic [SCALE_W-1:0] clamp(input logic [SCALE_W:0] v);
        if (ovf(v))
            return v[SCALE_W] ? {1'b1, {(SCALE_W-1){1'b0}}} : {1'b0, {(SCALE_W-1){1'b1}}};
        return v[SCALE_W-1:0];
    endfunction

    // Leading-zero count of m[MANT_W-2:0]; the highest set bit wins
    always_comb begin
        lz = SH_W'(MANT_W - 1);
        for (int i = 0; i < MANT_W - 1; i++) begin
            if (m_q[i]) lz = SH_W'(MANT_W - 2 - i);
        end
    end

    assign k      = (lz < SH_W'(SHIFT_STEP)) ? lz : SH_W'(SHIFT_STEP);
    assign sc_ext = {sc_q[SCALE_W-1], sc_q};
    assign sc_dec = sc_ext - (SCALE_W+1)'(k);
    assign sc_inc = sc_ext + 1'b1;

    // State register; reset aborts any operand in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and next datapath values
    always_comb begin
        state_nx = state;
        m_nx     = m_q;
        sc_nx    = sc_q;
        cnt_nx   = cnt_q;
        sat_nx   = sat_q;
        ov_nx    = ov_q;
        so_nx    = so_q;
        mo_nx    = mo_q;
        sa_nx    = sa_q;
        rs_nx    = rs_q;
        st_nx    = st_q;
        z_nx     = z_q;
        sat_o_nx = sat_o_q;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    m_nx     = bus.mant_in;
                    sc_nx    = bus.scale_in;
                    cnt_nx   = '0;
                    sat_nx   = 1'b0;
                    state_nx = NORM;
                end
            end
            NORM: begin
                if (m_q == '0) begin
                    ov_nx = 1'b1; z_nx = 1'b1; so_nx = '0; mo_nx = '0; sa_nx = '0;
                    rs_nx = 1'b0; st_nx = 1'b0; sat_o_nx = 1'b0;
                    state_nx = HOLD;
                end else if (m_q[MANT_W-1]) begin
                    ov_nx = 1'b1; z_nx = 1'b0; mo_nx = m_q >> 1; sa_nx = cnt_q;
                    rs_nx = 1'b1; st_nx = m_q[0];
                    so_nx = clamp(sc_inc);
                    sat_o_nx = sat_q | ovf(sc_inc);
                    state_nx = HOLD;
                end else if (m_q[MANT_W-2]) begin
                    ov_nx = 1'b1; z_nx = 1'b0; mo_nx = m_q; sa_nx = cnt_q;
                    rs_nx = 1'b0; st_nx = 1'b0; so_nx = sc_q; sat_o_nx = sat_q;
                    state_nx = HOLD;
                end else begin
                    // Keep shifting after a clamp so the mantissa is still normalised
                    m_nx   = m_q << k;
                    cnt_nx = cnt_q + k;
                    sc_nx  = clamp(sc_dec);
                    sat_nx = sat_q | ovf(sc_dec);
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    ov_nx    = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Working and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q <= '0; sc_q <= '0; cnt_q <= '0; sat_q <= 1'b0;
            ov_q <= 1'b0; so_q <= '0; mo_q <= '0; sa_q <= '0;
            rs_q <= 1'b0; st_q <= 1'b0; z_q <= 1'b0; sat_o_q <= 1'b0;
        end else begin
            m_q <= m_nx; sc_q <= sc_nx; cnt_q <= cnt_nx; sat_q <= sat_nx;
            ov_q <= ov_nx; so_q <= so_nx; mo_q <= mo_nx; sa_q <= sa_nx;
            rs_q <= rs_nx; st_q <= st_nx; z_q <= z_nx; sat_o_q <= sat_o_nx;
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = ov_q;
    assign bus.scale_out  = so_q;
    assign bus.mant_out   = mo_q;
    assign bus.shift_amt  = sa_q;
    assign bus.right_sh   = rs_q;
    assign bus.sticky     = st_q;
    assign bus.zero       = z_q;
    assign bus.sat        = sat_o_q;
    assign bus.exp_out    = so_q[ES-1:0];
    assign bus.regime_out = so_q[SCALE_W-2:ES];
    assign bus.scale_sign = so_q[SCALE_W-1];
    assign state_dbg      = state;
endmodule

// File: tb/tb_posit_norm_adjust.sv
// Directed bench for posit_norm_adjust with default parameters.
module tb_posit_norm_adjust;
    logic       clk;
    logic       reset_n;
    logic [1:0] state_dbg;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         lat;

    posit_norm_adjust_if #(.MANT_W(64), .SCALE_W(10), .ES(3)) bus ();

    posit_norm_adjust #(.MANT_W(64), .SCALE_W(10), .ES(3), .SHIFT_STEP(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after the acceptance edge; latency counts that edge as 1
    task automatic wait_out(output int l);
        l = 1;
        while (bus.out_valid !== 1'b1 && l < 200) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic run_op(input logic [63:0] m, input logic [9:0] s, output int l);
        check("accept_ready", 64'(bus.in_ready), 64'd1);
        bus.mant_in  = m;
        bus.scale_in = s;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.mant_in  = '0;
        bus.scale_in = '0;
        wait_out(l);
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("release_valid", 64'(bus.out_valid), 64'd0);
        check("release_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.mant_in   = '0;
        bus.scale_in  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready), 64'd1);
        check("rst_mant_out",  bus.mant_out, 64'd0);
        check("rst_scale_out", 64'(bus.scale_out), 64'd0);
        check("rst_state",     64'(state_dbg), 64'd0);

        // Already normalised
        run_op(64'h4000_0000_0000_0000, 10'd5, lat);
        check("norm_lat",    64'(lat), 64'd2);
        check("norm_mant",   bus.mant_out, 64'h4000_0000_0000_0000);
        check("norm_scale",  64'(bus.scale_out), 64'd5);
        check("norm_shift",  64'(bus.shift_amt), 64'd0);
        check("norm_exp",    64'(bus.exp_out), 64'd5);
        check("norm_regime", 64'(bus.regime_out), 64'd0);
        check("norm_sign",   64'(bus.scale_sign), 64'd0);
        check("norm_rsh",    64'(bus.right_sh), 64'd0);
        release_out();

        // Right shift with sticky
        run_op(64'hC000_0000_0000_0001, 10'd7, lat);
        check("rsh_lat",    64'(lat), 64'd2);
        check("rsh_mant",   bus.mant_out, 64'h6000_0000_0000_0000);
        check("rsh_sticky", 64'(bus.sticky), 64'd1);
        check("rsh_flag",   64'(bus.right_sh), 64'd1);
        check("rsh_scale",  64'(bus.scale_out), 64'd8);
        check("rsh_exp",    64'(bus.exp_out), 64'd0);
        check("rsh_regime", 64'(bus.regime_out), 64'd1);
        release_out();

        // Deep left shift: 62 zeros, 16 cycles of 4
        run_op(64'h1, 10'd0, lat);
        check("deep_lat",    64'(lat), 64'd18);
        check("deep_mant",   bus.mant_out, 64'h4000_0000_0000_0000);
        check("deep_shift",  64'(bus.shift_amt), 64'd62);
        check("deep_scale",  64'(bus.scale_out), 64'h3C2);
        check("deep_sign",   64'(bus.scale_sign), 64'd1);
        check("deep_exp",    64'(bus.exp_out), 64'd2);
        check("deep_regime", 64'(bus.regime_out), 64'h38);
        check("deep_sat",    64'(bus.sat), 64'd0);
        release_out();

        // Zero mantissa
        run_op(64'h0, 10'd9, lat);
        check("zero_lat",   64'(lat), 64'd2);
        check("zero_flag",  64'(bus.zero), 64'd1);
        check("zero_scale", 64'(bus.scale_out), 64'd0);
        check("zero_mant",  bus.mant_out, 64'd0);
        release_out();

        // Negative saturation: -510 - 62 clamps to -512
        run_op(64'h1, 10'h202, lat);
        check("nsat_lat",   64'(lat), 64'd18);
        check("nsat_scale", 64'(bus.scale_out), 64'h200);
        check("nsat_flag",  64'(bus.sat), 64'd1);
        check("nsat_shift", 64'(bus.shift_amt), 64'd62);
        check("nsat_zero",  64'(bus.zero), 64'd0);
        release_out();

        // Positive saturation on right shift: 511 + 1 clamps to 511
        run_op(64'h8000_0000_0000_0000, 10'h1FF, lat);
        check("psat_scale",  64'(bus.scale_out), 64'h1FF);
        check("psat_flag",   64'(bus.sat), 64'd1);
        check("psat_mant",   bus.mant_out, 64'h4000_0000_0000_0000);
        check("psat_sticky", 64'(bus.sticky), 64'd0);
        release_out();

        // Partial step: L=3, single shift cycle
        run_op(64'h0800_0000_0000_0000, 10'd3, lat);
        check("l3_lat",   64'(lat), 64'd3);
        check("l3_mant",  bus.mant_out, 64'h4000_0000_0000_0000);
        check("l3_shift", 64'(bus.shift_amt), 64'd3);
        check("l3_scale", 64'(bus.scale_out), 64'd0);
        check("l3_sat",   64'(bus.sat), 64'd0);
        release_out();

        // Backpressure with a second operand waiting
        run_op(64'h2000_0000_0000_0000, 10'd1, lat);
        check("bp_lat", 64'(lat), 64'd3);
        bus.mant_in  = 64'h8000_0000_0000_0002;
        bus.scale_in = 10'd20;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_ready", 64'(bus.in_ready), 64'd0);
            check("bp_mant",  bus.mant_out, 64'h4000_0000_0000_0000);
            check("bp_scale", 64'(bus.scale_out), 64'd0);
            check("bp_shift", 64'(bus.shift_amt), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_rel_valid", 64'(bus.out_valid), 64'd0);
        check("bp_rel_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.mant_in  = '0;
        bus.scale_in = '0;
        wait_out(lat);
        check("bp2_lat",   64'(lat), 64'd2);
        check("bp2_mant",  bus.mant_out, 64'h4000_0000_0000_0001);
        check("bp2_scale", 64'(bus.scale_out), 64'd21);
        check("bp2_rsh",   64'(bus.right_sh), 64'd1);
        check("bp2_stk",   64'(bus.sticky), 64'd0);
        release_out();

        // Reset in the middle of a deep shift
        bus.mant_in  = 64'h1;
        bus.scale_in = 10'd0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("mrst_valid", 64'(bus.out_valid), 64'd0);
        check("mrst_ready", 64'(bus.in_ready), 64'd1);
        check("mrst_mant",  bus.mant_out, 64'd0);
        check("mrst_scale", 64'(bus.scale_out), 64'd0);
        check("mrst_rsh",   64'(bus.right_sh), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_ready", 64'(bus.in_ready), 64'd1);
        run_op(64'h0400_0000_0000_0000, 10'h3FD, lat);
        check("post_lat",   64'(lat), 64'd3);
        check("post_mant",  bus.mant_out, 64'h4000_0000_0000_0000);
        check("post_scale", 64'(bus.scale_out), 64'h3F9);
        check("post_shift", 64'(bus.shift_amt), 64'd4);
        check("post_sat",   64'(bus.sat), 64'd0);
        release_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
